instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the byte-wise instruction fetch controller.
package instr_fetch_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // An instruction is assembled from this many memory bytes
  localparam int BYTES_PER_INSTR = 4;

  // Default byte-address width
  localparam int DEFAULT_ADDR_W = 32;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller sitting in front of a byte-wide memory with a
// registered read port. A program loader can write whole words; a fetch
// reads four consecutive bytes and assembles them little-endian into one
// 32-bit instruction, held until the consumer accepts it.
// Optional build macro: FETCH_ALIGN_CHECK_EN rejects fetches whose address
// is not word aligned and flags them on misalign_err.
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i_top,
  input  logic              rst_i_top,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_rdy,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [31:0]       load_data,
  output logic              load_ack,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Adr,
  output logic [31:0]       WriteData,
  input  logic [7:0]        instr8bit_top,
  output logic              misalign_err
);

  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_INSTR - 1);
  localparam logic [ADDR_W-1:0] ADR_ONE   = ADDR_W'(1);

  fetch_state_e      state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;

`ifdef FETCH_ALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  // State, byte counter, latched pc and assembly register; reset wipes any partial word
  always_ff @(posedge clk_i_top) begin
    if (rst_i_top) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      pc_q    <= '0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // One-cycle misalignment flag following a rejected fetch
  always_ff @(posedge clk_i_top) begin
    if (rst_i_top) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  // Next-state logic and memory-side outputs; loads win over fetches in IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    fetch_rdy = 1'b0;
    MemWrite  = 1'b0;
    Adr       = '0;
    WriteData = 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (load_req) begin
          MemWrite  = 1'b1;
          Adr       = load_adr;
          WriteData = load_data;
          state_d   = LOAD;
        end else begin
          fetch_rdy = 1'b1;
          if (fetch_req) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (fetch_pc[1:0] != 2'b00) begin
              misalign_d = 1'b1;
            end else
`endif
            begin
              pc_d    = fetch_pc;
              cnt_d   = 2'd0;
              Adr     = fetch_pc;
              state_d = FETCH;
            end
          end
        end
      end

      LOAD: begin
        state_d = IDLE;
      end

      FETCH: begin
        case (cnt_q)
          2'd0:    instr_d[7:0]   = instr8bit_top;
          2'd1:    instr_d[15:8]  = instr8bit_top;
          2'd2:    instr_d[23:16] = instr8bit_top;
          default: instr_d[31:24] = instr8bit_top;
        endcase
        if (cnt_q == LAST_BYTE) begin
          cnt_d   = 2'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 2'd1;
          Adr   = pc_q + ADDR_W'(cnt_q) + ADR_ONE;
        end
      end

      HOLD: begin
        if (instr_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instr_valid = (state_q == HOLD);
  assign load_ack    = (state_q == LOAD);
  assign instr       = instr_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a 32-bit-address instance for the main
// behaviour and an 8-bit-address instance for address wrap-around, each
// backed by a small byte memory with a registered read port.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        fetchReq;
  logic [31:0] fetchPc;
  logic        fetchRdy;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic        loadReq;
  logic [31:0] loadAdr;
  logic [31:0] loadData;
  logic        loadAck;
  logic        memWrite;
  logic [31:0] adr;
  logic [31:0] writeData;
  logic [7:0]  rdByte;
  logic        misalignErr;

  logic        fetchReq8;
  logic [7:0]  fetchPc8;
  logic        fetchRdy8;
  logic        instrValid8;
  logic        instrReady8;
  logic [31:0] instr8;
  logic        loadReq8;
  logic [7:0]  loadAdr8;
  logic [31:0] loadData8;
  logic        loadAck8;
  logic        memWrite8;
  logic [7:0]  adr8;
  logic [31:0] writeData8;
  logic [7:0]  rdByte8;
  logic        misalignErr8;

  logic [7:0]  mem  [0:255];
  logic [7:0]  mem8 [0:255];

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.ADDR_W(32)) dut (
    .clk_i_top    (clk),
    .rst_i_top    (rst),
    .fetch_req    (fetchReq),
    .fetch_pc     (fetchPc),
    .fetch_rdy    (fetchRdy),
    .instr_valid  (instrValid),
    .instr_ready  (instrReady),
    .instr        (instr),
    .load_req     (loadReq),
    .load_adr     (loadAdr),
    .load_data    (loadData),
    .load_ack     (loadAck),
    .MemWrite     (memWrite),
    .Adr          (adr),
    .WriteData    (writeData),
    .instr8bit_top(rdByte),
    .misalign_err (misalignErr)
  );

  instr_fetch_ctrl #(.ADDR_W(8)) dut8 (
    .clk_i_top    (clk),
    .rst_i_top    (rst),
    .fetch_req    (fetchReq8),
    .fetch_pc     (fetchPc8),
    .fetch_rdy    (fetchRdy8),
    .instr_valid  (instrValid8),
    .instr_ready  (instrReady8),
    .instr        (instr8),
    .load_req     (loadReq8),
    .load_adr     (loadAdr8),
    .load_data    (loadData8),
    .load_ack     (loadAck8),
    .MemWrite     (memWrite8),
    .Adr          (adr8),
    .WriteData    (writeData8),
    .instr8bit_top(rdByte8),
    .misalign_err (misalignErr8)
  );

  // Byte memory behind the 32-bit instance: word writes, registered byte reads
  always @(posedge clk) begin
    if (memWrite) begin
      mem[adr[7:0]]         <= writeData[7:0];
      mem[adr[7:0] + 8'd1]  <= writeData[15:8];
      mem[adr[7:0] + 8'd2]  <= writeData[23:16];
      mem[adr[7:0] + 8'd3]  <= writeData[31:24];
    end else begin
      rdByte <= mem[adr[7:0]];
    end
  end

  // Byte memory behind the 8-bit instance; read only
  always @(posedge clk) begin
    rdByte8 <= mem8[adr8];
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i);
      mem8[i] = 8'(i);
    end
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lReq, input logic [31:0] lAdr, input logic [31:0] lData,
                               input logic fReq, input logic [31:0] fPc, input logic iRdy);
    loadReq    = lReq;
    loadAdr    = lAdr;
    loadData   = lData;
    fetchReq   = fReq;
    fetchPc    = fPc;
    instrReady = iRdy;
    #1;
  endtask

  // Accept a fetch and walk it to the first HOLD cycle, checking addresses and timing
  task automatic fetchToHold(input logic [31:0] pc, input logic [31:0] expInstr);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, pc, 1'b0);
    checkOutput("accept_rdy", {31'd0, fetchRdy}, 32'd1);
    checkOutput("accept_adr", adr, pc);
    checkOutput("accept_we", {31'd0, memWrite}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      if (i <= 3) checkOutput("fetch_adr", adr, pc + 32'(i));
      checkOutput("valid_timing", {31'd0, instrValid}, (i == 5) ? 32'd1 : 32'd0);
    end
    checkOutput("instr_word", instr, expInstr);
  endtask

  // Accept the held instruction and confirm the return to IDLE
  task automatic releaseHold();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("release_valid", {31'd0, instrValid}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("release_valid_low", {31'd0, instrValid}, 32'd0);
    checkOutput("release_idle", {31'd0, fetchRdy}, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    fetchReq8   = 1'b0;
    fetchPc8    = 8'd0;
    instrReady8 = 1'b0;
    loadReq8    = 1'b0;
    loadAdr8    = 8'd0;
    loadData8   = 32'd0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset state
    checkOutput("rst_valid", {31'd0, instrValid}, 32'd0);
    checkOutput("rst_ack", {31'd0, loadAck}, 32'd0);
    checkOutput("rst_we", {31'd0, memWrite}, 32'd0);
    checkOutput("rst_adr", adr, 32'd0);
    checkOutput("rst_wdata", writeData, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_misalign", {31'd0, misalignErr}, 32'd0);
    checkOutput("rst_rdy", {31'd0, fetchRdy}, 32'd1);
    checkOutput("rst_instr8", instr8, 32'd0);

    // Program load of 0x00852020 at address 0, then fetch it back
    applyStimulus(1'b1, 32'd0, 32'h0085_2020, 1'b0, 32'd0, 1'b0);
    checkOutput("load_we", {31'd0, memWrite}, 32'd1);
    checkOutput("load_adr", adr, 32'd0);
    checkOutput("load_wdata", writeData, 32'h0085_2020);
    checkOutput("load_rdy", {31'd0, fetchRdy}, 32'd0);
    checkOutput("load_ack_early", {31'd0, loadAck}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("load_ack", {31'd0, loadAck}, 32'd1);
    checkOutput("load_ack_we", {31'd0, memWrite}, 32'd0);
    checkOutput("load_ack_wdata", writeData, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("load_ack_end", {31'd0, loadAck}, 32'd0);
    fetchToHold(32'd0, 32'h0085_2020);
    releaseHold();

    // Simultaneous load and fetch: the write goes first
    applyStimulus(1'b1, 32'd8, 32'hDEAD_BEEF, 1'b1, 32'd8, 1'b0);
    checkOutput("prio_we", {31'd0, memWrite}, 32'd1);
    checkOutput("prio_rdy", {31'd0, fetchRdy}, 32'd0);
    checkOutput("prio_adr", adr, 32'd8);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd8, 1'b0);
    checkOutput("prio_ack", {31'd0, loadAck}, 32'd1);
    checkOutput("prio_rdy_load", {31'd0, fetchRdy}, 32'd0);
    tick();
    fetchToHold(32'd8, 32'hDEAD_BEEF);
    releaseHold();

    // Consumer stalls in HOLD while a load waits
    fetchToHold(32'd4, 32'h0706_0504);
    for (int j = 0; j < 3; j++) begin
      tick();
      applyStimulus(1'b1, 32'h20, 32'h1122_3344, 1'b0, 32'd0, 1'b0);
      checkOutput("stall_valid", {31'd0, instrValid}, 32'd1);
      checkOutput("stall_instr", instr, 32'h0706_0504);
      checkOutput("stall_no_ack", {31'd0, loadAck}, 32'd0);
      checkOutput("stall_no_we", {31'd0, memWrite}, 32'd0);
    end
    tick();
    applyStimulus(1'b1, 32'h20, 32'h1122_3344, 1'b0, 32'd0, 1'b1);
    checkOutput("stall_release", {31'd0, instrValid}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h20, 32'h1122_3344, 1'b0, 32'd0, 1'b0);
    checkOutput("late_load_we", {31'd0, memWrite}, 32'd1);
    checkOutput("late_load_adr", adr, 32'h20);
    checkOutput("late_load_valid", {31'd0, instrValid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("late_load_ack", {31'd0, loadAck}, 32'd1);
    tick();

    // Reset at byte k=2 of a fetch discards the partial word
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("midrst_valid", {31'd0, instrValid}, 32'd0);
    checkOutput("midrst_instr", instr, 32'd0);
    checkOutput("midrst_adr", adr, 32'd0);
    checkOutput("midrst_we", {31'd0, memWrite}, 32'd0);
    checkOutput("midrst_wdata", writeData, 32'd0);
    checkOutput("midrst_ack", {31'd0, loadAck}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      checkOutput("midrst_no_valid", {31'd0, instrValid}, 32'd0);
    end
    fetchToHold(32'd0, 32'h0085_2020);
    releaseHold();

    // Reset during the write cycle suppresses the acknowledge
    applyStimulus(1'b1, 32'h40, 32'hCAFE_F00D, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("wrst_no_ack", {31'd0, loadAck}, 32'd0);
    checkOutput("wrst_idle", {31'd0, fetchRdy}, 32'd1);

    // Unaligned fetch at pc=2
`ifdef FETCH_ALIGN_CHECK_EN
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd2, 1'b0);
    checkOutput("mis_we", {31'd0, memWrite}, 32'd0);
    checkOutput("mis_adr", adr, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("mis_flag", {31'd0, misalignErr}, 32'd1);
    checkOutput("mis_idle", {31'd0, fetchRdy}, 32'd1);
    checkOutput("mis_adr_idle", adr, 32'd0);
    tick();
    checkOutput("mis_flag_end", {31'd0, misalignErr}, 32'd0);
    checkOutput("mis_no_valid", {31'd0, instrValid}, 32'd0);
`else
    fetchToHold(32'd2, 32'h0504_0085);
    checkOutput("unaligned_no_flag", {31'd0, misalignErr}, 32'd0);
    releaseHold();
`endif

    // 8-bit address instance wraps from 0xFE through 0x01
    fetchReq8 = 1'b1;
    fetchPc8  = 8'hFE;
    #1;
    checkOutput("wrap_adr0", {24'd0, adr8}, 32'h0000_00FE);
    tick();
    fetchReq8 = 1'b0;
    fetchPc8  = 8'd0;
    #1;
    checkOutput("wrap_adr1", {24'd0, adr8}, 32'h0000_00FF);
    tick();
    checkOutput("wrap_adr2", {24'd0, adr8}, 32'h0000_0000);
    tick();
    checkOutput("wrap_adr3", {24'd0, adr8}, 32'h0000_0001);
    tick();
    checkOutput("wrap_not_valid", {31'd0, instrValid8}, 32'd0);
    tick();
    checkOutput("wrap_valid", {31'd0, instrValid8}, 32'd1);
    checkOutput("wrap_instr", instr8, 32'h0100_FFFE);
    instrReady8 = 1'b1;
    tick();
    instrReady8 = 1'b0;
    #1;
    checkOutput("wrap_idle", {31'd0, fetchRdy8}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
